// File: rtl/vending_machine.sv
// -----------------------------------------------------------------------------
// vending_machine
//
// Coin-operated vending controller for a 15-unit product. Accepts at most one
// coin per cycle (5 or 10 units). Dispenses when credit reaches 15 and returns
// 5 units of change when credit would reach 20.
//
// Ports:
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous, active-high reset (priority over coin inputs)
//   i   : 10-unit coin strobe
//   j   : 5-unit coin strobe
//   x   : dispense product, registered one-cycle pulse
//   y   : return 5-unit change, registered one-cycle pulse (only with x)
// -----------------------------------------------------------------------------
module vending_machine (
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic j,
  output logic x,
  output logic y
);

  typedef enum logic [1:0] {
    S0  = 2'b00,
    S5  = 2'b01,
    S10 = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_x;
  logic   r_y;
  logic   w_x_nxt;
  logic   w_y_nxt;
  logic   w_coin5;
  logic   w_coin10;

  // Both strobes together is illegal and decodes as "no coin".
  assign w_coin5  = j & ~i;
  assign w_coin10 = i & ~j;

  // Next-state and next-output decode. Outputs are decoded from the current
  // state plus the coin being sampled, then registered, so x/y appear on the
  // same edge that accepts the completing coin.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = 1'b0;
    w_y_nxt     = 1'b0;
    case (r_state)
      S0: begin
        if (w_coin5)       w_state_nxt = S5;
        else if (w_coin10) w_state_nxt = S10;
      end
      S5: begin
        if (w_coin5) begin
          w_state_nxt = S10;
        end else if (w_coin10) begin
          w_state_nxt = S0;
          w_x_nxt     = 1'b1;
        end
      end
      S10: begin
        if (w_coin5) begin
          w_state_nxt = S0;
          w_x_nxt     = 1'b1;
        end else if (w_coin10) begin
          // Overpayment: 20 credited, vend and hand back 5.
          w_state_nxt = S0;
          w_x_nxt     = 1'b1;
          w_y_nxt     = 1'b1;
        end
      end
      default: begin
        // Unused encoding recovers to idle without vending.
        w_state_nxt = S0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S0;
      r_x     <= 1'b0;
      r_y     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  assign x = r_x;
  assign y = r_y;

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  logic clk;
  logic rst;
  logic i;
  logic j;
  logic x;
  logic y;

  vending_machine dut (
    .clk(clk),
    .rst(rst),
    .i  (i),
    .j  (j),
    .x  (x),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  rst;
    logic  i;
    logic  j;
    logic  ex;
    logic  ey;
    string name;
  } vec_t;

  typedef struct {
    logic  ex;
    logic  ey;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic ii, input logic jj,
                     input logic ex, input logic ey, input string nm);
    vec_t v;
    v.rst = r; v.i = ii; v.j = jj; v.ex = ex; v.ey = ey; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, push the expectation, then pop and compare
  // once the registered outputs have settled after the edge.
  task automatic step(input logic r, input logic ii, input logic jj,
                      input logic ex, input logic ey, input string nm);
    exp_t e;
    rst = r; i = ii; j = jj;
    e.ex = ex; e.ey = ey; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_tests++;
    if (x !== e.ex || y !== e.ey) begin
      n_fail++;
      $display("FAIL %s: got x=%b y=%b, expected x=%b y=%b", e.name, x, y, e.ex, e.ey);
    end
  endtask

  // Reference: integer credit accounting, independent of state encoding.
  int   m_credit;
  logic m_x;
  logic m_y;

  task automatic model(input logic r, input logic ii, input logic jj);
    int v;
    int s;
    if (r) begin
      m_credit = 0; m_x = 1'b0; m_y = 1'b0;
    end else begin
      v = (ii && !jj) ? 10 : ((jj && !ii) ? 5 : 0);
      s = m_credit + v;
      if (s >= 15) begin
        m_x = 1'b1; m_y = (s == 20); m_credit = 0;
      end else begin
        m_x = 1'b0; m_y = 1'b0; m_credit = s;
      end
    end
  endtask

  initial begin
    rst = 1'b1; i = 1'b0; j = 1'b0;

    // rst, i, j, expected x, expected y
    add(1, 0, 0, 0, 0, "reset_state");
    add(0, 0, 0, 0, 0, "idle_s0");
    add(0, 0, 1, 0, 0, "s0_coin5");
    add(0, 1, 0, 1, 0, "s5_coin10_vend");
    add(0, 0, 0, 0, 0, "vend_pulse_clears");
    add(1, 0, 0, 0, 0, "reset2");
    add(0, 1, 0, 0, 0, "s0_coin10");
    add(0, 1, 0, 1, 1, "s10_coin10_change");
    add(0, 0, 0, 0, 0, "change_pulse_clears");
    add(1, 0, 0, 0, 0, "reset3");
    add(0, 1, 1, 0, 0, "illegal_ignored");
    add(0, 1, 0, 0, 0, "legal_after_illegal");
    add(0, 0, 1, 1, 0, "s10_coin5_vend");
    add(0, 0, 1, 0, 0, "five_1");
    add(0, 0, 1, 0, 0, "five_2");
    add(0, 0, 1, 1, 0, "five_3_vend");
    add(1, 0, 0, 0, 0, "reset4");
    add(0, 0, 1, 0, 0, "credit5");
    add(1, 1, 0, 0, 0, "reset_beats_coin");
    add(0, 1, 0, 0, 0, "credit_discarded");
    for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, "idle_s10_hold");
    add(0, 0, 1, 1, 0, "idle_then_vend");
    add(0, 1, 0, 0, 0, "b2b_coin10a");
    add(0, 1, 0, 1, 1, "b2b_change1");
    add(0, 1, 0, 0, 0, "b2b_restart");
    add(0, 1, 0, 1, 1, "b2b_change2");
    add(0, 0, 1, 0, 0, "b2b_coin5");
    add(0, 1, 1, 0, 0, "s5_illegal_hold");
    add(0, 1, 0, 1, 0, "s5_held_vend");

    foreach (vecs[k])
      step(vecs[k].rst, vecs[k].i, vecs[k].j, vecs[k].ex, vecs[k].ey, vecs[k].name);

    // Back-to-back vends with no idle gap: 10,5 then 10,5 again.
    step(1, 0, 0, 0, 0, "seq_reset");
    step(0, 1, 0, 0, 0, "seq_a_10");
    step(0, 0, 1, 1, 0, "seq_a_5_vend");
    step(0, 1, 0, 0, 0, "seq_b_10");
    step(0, 0, 1, 1, 0, "seq_b_5_vend");
    step(0, 0, 1, 0, 0, "seq_c_5");

    // Random traffic against the credit model.
    step(1, 0, 0, 0, 0, "rand_reset");
    m_credit = 0;
    for (int k = 0; k < 300; k++) begin
      logic r, ii, jj;
      r  = ($urandom_range(0, 31) == 0);
      ii = $urandom_range(0, 1);
      jj = $urandom_range(0, 1);
      model(r, ii, jj);
      step(r, ii, jj, m_x, m_y, "random");
    end

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
